// File: rtl/irq_gateway.sv
// irq_gateway: per-source interrupt conditioning (level / rising edge) into single-cycle PLIC requests.
// Optional build macro IRQ_GW_SYNC_EN inserts a 2-flop synchronizer on irq_raw_i.
module irq_gateway #(
    parameter int NSOURCES     = 8,
    parameter int SRC_ID_WIDTH = 3,
    parameter int CNT_WIDTH    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NSOURCES-1:0]     irq_raw_i,
    input  logic [NSOURCES-1:0]     mode_wdata_i,
    input  logic                    mode_we_i,
    input  logic                    complete_i,
    input  logic [SRC_ID_WIDTH-1:0] complete_id_i,
    input  logic                    ovf_clr_i,
    output logic [NSOURCES-1:0]     src_o,
    output logic [NSOURCES-1:0]     busy_o,
    output logic [NSOURCES-1:0]     ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NSOURCES-1:0]                mode_q;
    logic [NSOURCES-1:0]                sDly_q;
    logic [NSOURCES-1:0]                ovf_q, ovf_d;
    logic [NSOURCES-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    state_e                             state_q [NSOURCES];
    state_e                             state_d [NSOURCES];

    logic [NSOURCES-1:0] sIn;
    logic [NSOURCES-1:0] edgeHit;
    logic [NSOURCES-1:0] edgeEvt;
    logic [NSOURCES-1:0] cplHit;
    logic [31:0]         cplId;

`ifdef IRQ_GW_SYNC_EN
    logic [NSOURCES-1:0] syncMeta_q, syncOut_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            syncMeta_q <= '0;
            syncOut_q  <= '0;
        end else begin
            syncMeta_q <= irq_raw_i;
            syncOut_q  <= syncMeta_q;
        end
    end

    assign sIn = syncOut_q;
`else
    assign sIn = irq_raw_i;
`endif

    assign edgeHit = sIn & ~sDly_q;
    assign edgeEvt = mode_q & edgeHit;
    // Widened so IDs beyond the source range (or 0) never alias onto a real source.
    assign cplId   = 32'(complete_id_i);

    always_comb begin
        cplHit = '0;
        for (int i = 0; i < NSOURCES; i++) begin
            cplHit[i] = complete_i && (cplId == 32'(i + 1));
        end
    end

    always_comb begin
        ovf_d = ovf_q & ~{NSOURCES{ovf_clr_i}};
        for (int i = 0; i < NSOURCES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (mode_q[i] ? edgeHit[i] : sIn[i]) begin
                        state_d[i] = REQ;
                    end
                end
                REQ: begin
                    state_d[i] = WAIT;
                    if (edgeEvt[i]) begin
                        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                WAIT: begin
                    if (cplHit[i] && !mode_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cplHit[i]) begin
                        // A coincident edge replaces the request being consumed, so cnt is unchanged.
                        if (edgeEvt[i]) begin
                            state_d[i] = REQ;
                            if (cnt_q[i] == CNT_MAX) begin
                                ovf_d[i] = 1'b1;
                                cnt_d[i] = cnt_q[i] - CNT_ONE;
                            end
                        end else if (cnt_q[i] != '0) begin
                            state_d[i] = REQ;
                            cnt_d[i]   = cnt_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else if (edgeEvt[i]) begin
                        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (mode_we_i && (mode_wdata_i[i] != mode_q[i])) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= '0;
            sDly_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < NSOURCES; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            if (mode_we_i) mode_q <= mode_wdata_i;
            sDly_q <= sIn;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < NSOURCES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        src_o  = '0;
        busy_o = '0;
        for (int i = 0; i < NSOURCES; i++) begin
            src_o[i]  = (state_q[i] == REQ);
            busy_o[i] = (state_q[i] != IDLE);
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_irq_gateway.sv
// tb_irq_gateway: directed vector table, hand sequences for latency/reset, and
// randomized traffic against a behavioural model of the gateway.
module tb_irq_gateway;

`ifdef IRQ_GW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int QMAX = 3;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] irqRaw;
    logic [7:0] modeWdata;
    logic       modeWe;
    logic       complete;
    logic [3:0] completeId;
    logic       ovfClr;
    logic [7:0] srcOut;
    logic [7:0] busyOut;
    logic [7:0] ovfOut;

    int testCount = 0;
    int failCount = 0;

    irq_gateway #(
        .NSOURCES    (8),
        .SRC_ID_WIDTH(4),
        .CNT_WIDTH   (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .irq_raw_i    (irqRaw),
        .mode_wdata_i (modeWdata),
        .mode_we_i    (modeWe),
        .complete_i   (complete),
        .complete_id_i(completeId),
        .ovf_clr_i    (ovfClr),
        .src_o        (srcOut),
        .busy_o       (busyOut),
        .ovf_o        (ovfOut)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural model: each source is "busy" from request until its completion,
    // with a count of queued edges still owed a request.
    logic [7:0] mMode, mBusy, mPulse, mOvf, mD1, mD2, mSPrev;
    int         mQueued [8];

    task automatic modelReset();
        mMode = '0; mBusy = '0; mPulse = '0; mOvf = '0;
        mD1 = '0; mD2 = '0; mSPrev = '0;
        for (int i = 0; i < 8; i++) mQueued[i] = 0;
    endtask

    task automatic modelStep(input logic [7:0] raw, input logic we, input logic [7:0] wdata,
                             input logic cpl, input logic [3:0] id, input logic clr);
        logic [7:0] s, rise, nOvf;
        bit         e, hit;
        int         total;
`ifdef IRQ_GW_SYNC_EN
        s = mD2;
`else
        s = raw;
`endif
        rise = s & ~mSPrev;
        nOvf = clr ? 8'h00 : mOvf;
        for (int i = 0; i < 8; i++) begin
            e   = mMode[i] & rise[i];
            hit = cpl && (int'(id) == i + 1);
            if (!mBusy[i]) begin
                if (mMode[i] ? rise[i] : s[i]) begin
                    mBusy[i]  = 1'b1;
                    mPulse[i] = 1'b1;
                end
            end else if (mPulse[i]) begin
                mPulse[i] = 1'b0;
                if (e) begin
                    if (mQueued[i] == QMAX) nOvf[i] = 1'b1;
                    else                    mQueued[i]++;
                end
            end else if (hit) begin
                if (!mMode[i]) begin
                    mBusy[i] = 1'b0;
                end else begin
                    total = mQueued[i] + int'(e);
                    if (total > QMAX) begin
                        nOvf[i] = 1'b1;
                        total   = QMAX;
                    end
                    if (total > 0) begin
                        mPulse[i]  = 1'b1;
                        mQueued[i] = total - 1;
                    end else begin
                        mBusy[i] = 1'b0;
                    end
                end
            end else if (e) begin
                if (mQueued[i] == QMAX) nOvf[i] = 1'b1;
                else                    mQueued[i]++;
            end
            if (we && (wdata[i] != mMode[i])) mQueued[i] = 0;
        end
        mOvf   = nOvf;
        if (we) mMode = wdata;
        mSPrev = s;
        mD2    = mD1;
        mD1    = raw;
    endtask

    // Called at a falling edge: drives inputs, advances one clock, returns at the next falling edge.
    task automatic applyStimulus(input logic [7:0] raw, input logic we, input logic [7:0] wdata,
                                 input logic cpl, input logic [3:0] id, input logic clr);
        irqRaw = raw; modeWe = we; modeWdata = wdata;
        complete = cpl; completeId = id; ovfClr = clr;
        modelStep(raw, we, wdata, cpl, id, clr);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [7:0] raw;
        logic       we;
        logic [7:0] wdata;
        logic       cpl;
        logic [3:0] id;
        logic       clr;
        logic [7:0] expSrc;
        logic [7:0] expBusy;
        logic [7:0] expOvf;
    } vec_t;

    vec_t tbl[$];

    task automatic addRow(input logic [7:0] raw, input logic we, input logic [7:0] wdata,
                          input logic cpl, input logic [3:0] id, input logic clr,
                          input logic [7:0] eSrc, input logic [7:0] eBusy, input logic [7:0] eOvf);
        vec_t v;
        v.raw = raw; v.we = we; v.wdata = wdata; v.cpl = cpl; v.id = id; v.clr = clr;
        v.expSrc = eSrc; v.expBusy = eBusy; v.expOvf = eOvf;
        tbl.push_back(v);
    endtask

    initial begin
        int         rr;
        int         nv;
        logic [7:0] raw;
        logic       we, cpl, clr;
        logic [7:0] wdata;
        logic [3:0] id;

        // raw     we  wdata  cpl id  clr  src    busy   ovf
        addRow(8'h00, 1, 8'h03, 0, 0, 0, 8'h00, 8'h00, 8'h00); // 0: src0/src1 edge mode
        addRow(8'h04, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 8'h00); // level src2
        addRow(8'h04, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 8'h00);
        addRow(8'h04, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 8'h00);
        addRow(8'h04, 0, 8'h00, 1, 3, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h04, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 8'h00); // 5: re-request
        addRow(8'h04, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 8'h00);
        addRow(8'h00, 0, 8'h00, 1, 3, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h01, 0, 8'h00, 0, 0, 0, 8'h01, 8'h01, 8'h00); // 10: edge src0
        addRow(8'h00, 0, 8'h00, 1, 1, 0, 8'h00, 8'h01, 8'h00); // completion in REQ ignored
        addRow(8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h00);
        addRow(8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h01); // 5th edge overflows
        addRow(8'h00, 0, 8'h00, 1, 1, 0, 8'h01, 8'h01, 8'h01);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h01); // 20
        addRow(8'h00, 0, 8'h00, 1, 1, 0, 8'h01, 8'h01, 8'h01);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h01);
        addRow(8'h00, 0, 8'h00, 1, 1, 0, 8'h01, 8'h01, 8'h01);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 8'h01);
        addRow(8'h00, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h01); // queue drained
        addRow(8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        addRow(8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 8'h02, 8'h00); // edge src1
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 8'h00);
        addRow(8'h02, 0, 8'h00, 1, 2, 0, 8'h02, 8'h02, 8'h00); // edge + completion
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 8'h00); // 30
        addRow(8'h00, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 8'h02, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 8'h00);
        addRow(8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'h02, 8'h00); // stray id 0
        addRow(8'h00, 0, 8'h00, 1, 9, 0, 8'h00, 8'h02, 8'h00); // stray id 9
        addRow(8'h00, 0, 8'h00, 1, 5, 0, 8'h00, 8'h02, 8'h00); // id 5, src4 idle
        addRow(8'h00, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h00, 1, 8'h0B, 0, 0, 0, 8'h00, 8'h00, 8'h00); // src3 edge mode
        addRow(8'h08, 0, 8'h00, 0, 0, 0, 8'h08, 8'h08, 8'h00); // 40
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h08, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h08, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h08, 1, 8'h03, 0, 0, 0, 8'h00, 8'h08, 8'h00); // src3 back to level
        addRow(8'h08, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 8'h00);
        addRow(8'h00, 0, 8'h00, 1, 4, 0, 8'h00, 8'h00, 8'h00);
        addRow(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        nv = tbl.size();

        rst_i = 1'b1;
        irqRaw = '0; modeWe = 1'b0; modeWdata = '0;
        complete = 1'b0; completeId = '0; ovfClr = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput("reset src", srcOut, 8'h00);
        checkOutput("reset busy", busyOut, 8'h00);
        checkOutput("reset ovf", ovfOut, 8'h00);
        rst_i = 1'b0;

        // Raw lines lead the table by LAT cycles so the conditioned input lines up with each row.
        for (int r = -LAT; r < nv; r++) begin
            rr = (r + LAT < nv) ? r + LAT : nv - 1;
            if (r < 0) begin
                applyStimulus(tbl[rr].raw, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
            end else begin
                applyStimulus(tbl[rr].raw, tbl[r].we, tbl[r].wdata, tbl[r].cpl, tbl[r].id, tbl[r].clr);
                checkOutput($sformatf("vec%0d src", r), srcOut, tbl[r].expSrc);
                checkOutput($sformatf("vec%0d busy", r), busyOut, tbl[r].expBusy);
                checkOutput($sformatf("vec%0d ovf", r), ovfOut, tbl[r].expOvf);
            end
        end

        // Latency of level source 5 from raw assertion to request pulse.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h20, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
            checkOutput($sformatf("latency c%0d src", c), {7'b0, srcOut[5]}, {7'b0, (c == LAT)});
            checkOutput($sformatf("latency c%0d busy", c), {7'b0, busyOut[5]}, {7'b0, (c >= LAT)});
        end
        repeat (3) applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 4'd6, 1'b0);
        checkOutput("latency release busy", busyOut, 8'h00);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkOutput("latency no repulse", srcOut, 8'h00);

        // Reset asserted while every source is in REQ.
        repeat (LAT) applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkOutput("pre-reset src", srcOut, 8'hFF);
        rst_i = 1'b1;
        #1;
        checkOutput("midreq reset src", srcOut, 8'h00);
        checkOutput("midreq reset busy", busyOut, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("in reset c%0d src", c), srcOut, 8'h00);
            checkOutput($sformatf("in reset c%0d busy", c), busyOut, 8'h00);
            checkOutput($sformatf("in reset c%0d ovf", c), ovfOut, 8'h00);
        end
        modelReset();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
            checkOutput($sformatf("post reset c%0d src", c), srcOut, 8'h00);
            checkOutput($sformatf("post reset c%0d busy", c), busyOut, 8'h00);
        end

        // Randomized traffic against the model.
        raw = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            raw   = raw ^ (8'($urandom) & 8'($urandom));
            we    = ($urandom_range(0, 39) == 0);
            wdata = 8'($urandom);
            cpl   = ($urandom_range(0, 2) == 0);
            id    = 4'($urandom_range(0, 9));
            clr   = ($urandom_range(0, 24) == 0);
            applyStimulus(raw, we, wdata, cpl, id, clr);
            checkOutput($sformatf("rand%0d src", n), srcOut, mPulse);
            checkOutput($sformatf("rand%0d busy", n), busyOut, mBusy);
            checkOutput($sformatf("rand%0d ovf", n), ovfOut, mOvf);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
